// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-stage store path.
//   store_size_e     : 2-bit store size, same encoding as the sel input
//   size_mask()      : byte-enable pattern of a store before lane shifting
//   storebuf_entry_t : one store-buffer entry {doubleword address, lane data, byte mask}
package riscv_pkg;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10,
    SD = 2'b11
  } store_size_e;

  // Entries hold the widest supported address; narrower AW is zero-extended.
  localparam int ENTRY_AW = 64;

  typedef struct packed {
    logic [ENTRY_AW-1:3] dw_addr;
    logic [63:0]         wdata;
    logic [7:0]          mask;
  } storebuf_entry_t;

  function automatic logic [7:0] size_mask(input store_size_e size);
    case (size)
      SB:      return 8'h01;
      SH:      return 8'h03;
      SW:      return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/riscv_store_align.sv
// Combinational store lane aligner.
//   size       : store size
//   offset     : address bits [2:0]
//   data       : right-justified store data
//   wdata      : data with unused bytes cleared, shifted into its byte lanes
//   mask       : byte-write enables for the doubleword
//   misaligned : store does not sit on its natural boundary
module riscv_store_align
  import riscv_pkg::*;
(
  input  store_size_e size,
  input  logic [2:0]  offset,
  input  logic [63:0] data,
  output logic [63:0] wdata,
  output logic [7:0]  mask,
  output logic        misaligned
);

  logic [7:0]  smask;
  logic [63:0] data_trim;

  always_comb begin
    smask = size_mask(size);
    data_trim = '0;
    for (int b = 0; b < 8; b++) begin
      data_trim[8*b +: 8] = smask[b] ? data[8*b +: 8] : 8'h00;
    end
    // Misaligned results are never enqueued, so overflow past lane 7 is harmless.
    mask  = smask << offset;
    wdata = data_trim << {offset, 3'b000};
    case (size)
      SB:      misaligned = 1'b0;
      SH:      misaligned = offset[0];
      SW:      misaligned = |offset[1:0];
      default: misaligned = |offset;
    endcase
  end

endmodule

// File: rtl/riscv_storebuf.sv
// Memory-stage store buffer.
//   valid/ready/sel/addr/data : store request in (sel = size)
//   ldvalid/ldaddr, hazard    : doubleword overlap of current load with any pending store
//   misaligned/badaddr        : one-cycle exception pulse and held faulting address
//   mem_valid/ready/addr/wdata/mask : in-order write drain to the dcache
//   empty                     : no pending stores
module riscv_storebuf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 64
) (
  input  logic          i_riscv_storebuf_clk,
  input  logic          i_riscv_storebuf_rst_n,
  input  logic          i_riscv_storebuf_valid,
  output logic          o_riscv_storebuf_ready,
  input  logic [1:0]    i_riscv_storebuf_sel,
  input  logic [AW-1:0] i_riscv_storebuf_addr,
  input  logic [63:0]   i_riscv_storebuf_data,
  input  logic [AW-1:0] i_riscv_storebuf_ldaddr,
  input  logic          i_riscv_storebuf_ldvalid,
  output logic          o_riscv_storebuf_hazard,
  output logic          o_riscv_storebuf_misaligned,
  output logic [AW-1:0] o_riscv_storebuf_badaddr,
  output logic          o_riscv_storebuf_mem_valid,
  input  logic          i_riscv_storebuf_mem_ready,
  output logic [AW-1:0] o_riscv_storebuf_mem_addr,
  output logic [63:0]   o_riscv_storebuf_mem_wdata,
  output logic [7:0]    o_riscv_storebuf_mem_mask,
  output logic          o_riscv_storebuf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic            clk;
  logic            rst_n;
  assign clk   = i_riscv_storebuf_clk;
  assign rst_n = i_riscv_storebuf_rst_n;

  storebuf_entry_t entries [DEPTH];
  storebuf_entry_t head;
  storebuf_entry_t new_entry;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            empty_q;
  logic            mis_q;
  logic [AW-1:0]   badaddr_q;

  logic [63:0]     addr_ext;
  logic [63:0]     ldaddr_ext;
  logic [63:0]     lane_wdata;
  logic [7:0]      lane_mask;
  logic            mis_req;
  logic            accept;
  logic            enq;
  logic            fault;
  logic            pop;
  logic [PW-1:0]   rel [DEPTH];
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match;

  assign addr_ext   = 64'(i_riscv_storebuf_addr);
  assign ldaddr_ext = 64'(i_riscv_storebuf_ldaddr);

  riscv_store_align u_align (
    .size       (store_size_e'(i_riscv_storebuf_sel)),
    .offset     (i_riscv_storebuf_addr[2:0]),
    .data       (i_riscv_storebuf_data),
    .wdata      (lane_wdata),
    .mask       (lane_mask),
    .misaligned (mis_req)
  );

  assign o_riscv_storebuf_ready     = (count != CW'(DEPTH));
  assign o_riscv_storebuf_mem_valid = (count != '0);

  assign accept = i_riscv_storebuf_valid && o_riscv_storebuf_ready;
  assign enq    = accept && !mis_req;
  assign fault  = accept && mis_req;
  assign pop    = o_riscv_storebuf_mem_valid && i_riscv_storebuf_mem_ready;

  always_comb begin
    new_entry.dw_addr = addr_ext[63:3];
    new_entry.wdata   = lane_wdata;
    new_entry.mask    = lane_mask;
  end

  always_comb begin
    count_next = count;
    case ({enq, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty_q   <= 1'b1;
      mis_q     <= 1'b0;
      badaddr_q <= '0;
    end else begin
      count   <= count_next;
      empty_q <= (count_next == '0);
      mis_q   <= fault;
      if (enq)   wr_ptr    <= wr_ptr + 1'b1;
      if (pop)   rd_ptr    <= rd_ptr + 1'b1;
      if (fault) badaddr_q <= i_riscv_storebuf_addr;
    end
  end

  // Storage needs no reset: count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq) entries[wr_ptr] <= new_entry;
  end

  assign head = entries[rd_ptr];

  assign o_riscv_storebuf_mem_addr   = AW'({head.dw_addr, 3'b000});
  assign o_riscv_storebuf_mem_wdata  = head.wdata;
  assign o_riscv_storebuf_mem_mask   = head.mask;
  assign o_riscv_storebuf_empty      = empty_q;
  assign o_riscv_storebuf_misaligned = mis_q;
  assign o_riscv_storebuf_badaddr    = badaddr_q;

  // A slot is live when its distance from the head (mod DEPTH) is below count;
  // the head is still live in the cycle it pops.
  always_comb begin
    live  = '0;
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]   = PW'(i) - rd_ptr;
      live[i]  = ({1'b0, rel[i]} < count);
      match[i] = (entries[i].dw_addr == ldaddr_ext[63:3]);
    end
  end

  assign o_riscv_storebuf_hazard = i_riscv_storebuf_ldvalid && |(live & match);

endmodule

// File: doc/riscv_storebuf.md
Name: riscv_storebuf

Overview:
Store-side counterpart of the load extension unit in the memory stage. It accepts store requests (size, address, data) and checks natural alignment. It shifts the store data into the correct byte lanes of a 64-bit doubleword and builds the byte-write mask. Accepted stores are queued in a small FIFO and drained to the data cache over a valid/ready handshake; the unit also reports load-address hazards against pending stores and raises misaligned-store exceptions.

Parameters:
DEPTH, 2, number of store-buffer entries (power of two, >=2)
AW, 64, address width

Ports:
i_riscv_storebuf_clk  in  1  clock, rising edge
i_riscv_storebuf_rst_n  in  1  asynchronous active-low reset
i_riscv_storebuf_valid  in  1  store request valid
o_riscv_storebuf_ready  out  1  buffer can accept a request
i_riscv_storebuf_sel  in  2  size: 00 sb, 01 sh, 10 sw, 11 sd
i_riscv_storebuf_addr  in  AW  byte address
i_riscv_storebuf_data  in  64  store data, right-justified
i_riscv_storebuf_ldaddr  in  AW  address of load currently in memory stage
i_riscv_storebuf_ldvalid  in  1  load present in memory stage
o_riscv_storebuf_hazard  out  1  load overlaps a pending store doubleword; stall load
o_riscv_storebuf_misaligned  out  1  misaligned-store exception pulse
o_riscv_storebuf_badaddr  out  AW  faulting address, valid with misaligned
o_riscv_storebuf_mem_valid  out  1  write request to dcache
i_riscv_storebuf_mem_ready  in  1  dcache accepts write
o_riscv_storebuf_mem_addr  out  AW  doubleword-aligned address, bits [2:0]=0
o_riscv_storebuf_mem_wdata  out  64  lane-aligned write data
o_riscv_storebuf_mem_mask  out  8  byte-write enables
o_riscv_storebuf_empty  out  1  no pending stores (used by fence)

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count cleared; mem_valid=0, misaligned=0, badaddr=0, hazard=0, empty=1, ready=1. Reset mid-drain discards all entries, including an in-flight mem_valid.
- ready = (count != DEPTH). Enqueue fires on valid && ready. No pass-through when full, even if a drain occurs in the same cycle.
- Alignment check uses offset = addr[2:0]:
  - sh is misaligned when addr[0]=1.
  - sw is misaligned when addr[1:0]!=0.
  - sd is misaligned when offset!=0.
  - sb is never misaligned.
- Misaligned request with valid && ready: not enqueued. misaligned=1 for exactly the next cycle, and badaddr is registered with the faulting address (held until the next fault).
- Lane alignment on enqueue:
  - Size mask: sb 0x01, sh 0x03, sw 0x0F, sd 0xFF.
  - mask = sizemask << offset.
  - wdata = (data with bytes above the size zeroed) << (8*offset).
  - Bytes outside the mask are 0.
  - Stored entry holds {addr[AW-1:3], wdata, mask}.
- Latency: an entry enqueued in cycle N drives mem_valid=1 in cycle N+1 from the FIFO head register.
- Drain: mem_valid = (count != 0). Head pops on mem_valid && mem_ready. mem_addr, wdata and mask stay stable while mem_valid && !mem_ready.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- hazard = ldvalid && any valid entry has addr[AW-1:3] == ldaddr[AW-1:3]. Combinational and conservative: it compares doublewords only. An entry popping in the current cycle is still compared.
- empty = (count == 0), registered.
- Stores are issued to the dcache strictly in program order; no store merging.

Decomposition:
- Shared package riscv_pkg:
  - store size enum (SB, SH, SW, SD) matching the 2-bit sel encoding.
  - function returning the 8-bit size mask for a given size.
  - typedef storebuf_entry_t.
- Sub-module riscv_store_align: combinational lane shifter, mask generator and misalignment detector. The top level holds the FIFO, counters, hazard compare and exception register.

Test Plan:
- sb, addr 0x1003, data 0xAB -> next cycle mem_valid=1, mem_addr 0x1000, mask 0x08, wdata 0x00000000AB000000.
- sh, addr 0x2006, data 0xFFFF1234 -> mask 0xC0, wdata 0x1234000000000000; sw, addr 0x2004, data 0xDEADBEEF -> mask 0xF0, wdata 0xDEADBEEF00000000.
- sw, addr 0x3002 -> no enqueue, misaligned=1 for one cycle, badaddr 0x3002, mem_valid stays 0; sd at 0x3000 still succeeds afterwards.
- Hold mem_ready=0 and issue 3 stores -> ready=0 after 2, the third waits; raise mem_ready -> drain in order, ready returns, empty=1 after the last pop.
- Pending sd at 0x4000, ldvalid with ldaddr 0x4005 -> hazard=1; ldaddr 0x4008 -> hazard=0; after the drain, ldaddr 0x4005 -> hazard=0.
- Assert rst_n low while mem_valid=1 with 2 entries -> mem_valid=0, empty=1, ready=1 immediately, without waiting for a clock edge.
